// File: rtl/wynik_pkg.sv
// Shared types and helpers for the result register stage and the
// arithmetic stages that reuse its classifier.
package wynik_pkg;

    typedef enum logic [1:0] {
        ST_OK     = 2'd0,
        ST_ZERO   = 2'd1,
        ST_ONEHOT = 2'd2,
        ST_ERR    = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        FS_EMPTY = 2'd0,
        FS_PART  = 2'd1,
        FS_FULL  = 2'd2
    } fifo_state_t;

    // Counters up to 32 bits wide share this helper; the caller truncates.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = 32'hFFFF_FFFF >> (32 - width);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/klasyfikator_wyniku.sv
// Combinational classifier turning a result/error pair into a status code.
module klasyfikator_wyniku
    import wynik_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] result,
    input  logic            error,
    output status_t         status
);

    // Error outranks everything; a single set bit clears to zero when ANDed with itself minus one.
    always_comb begin
        status = ST_OK;
        if (error) begin
            status = ST_ERR;
        end else if (result == '0) begin
            status = ST_ZERO;
        end else if ((result & (result - BITS'(1))) == '0) begin
            status = ST_ONEHOT;
        end
    end

endmodule

// File: rtl/rejestr_wyniku.sv
// Registered output stage: first-word-fall-through FIFO of classified results
// with valid/ready on both sides and saturating drop/error counters.
module rejestr_wyniku
    import wynik_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [BITS-1:0]  i_result,
    input  logic             i_error,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [BITS-1:0]  o_result,
    output logic             o_error,
    output status_t          o_status,
    output logic [CNT_W-1:0] o_drop_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef struct packed {
        logic [BITS-1:0] result;
        logic            error;
        status_t         status;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    fifo_state_t     state;
    fifo_state_t     state_nx;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nx;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] err_cnt;
    status_t         in_status;
    logic            wr_en;
    logic            rd_en;
    logic            drop_ev;

    klasyfikator_wyniku #(
        .BITS (BITS)
    ) u_klasyfikator (
        .result (i_result),
        .error  (i_error),
        .status (in_status)
    );

    assign o_valid = (state != FS_EMPTY);
    assign o_ready = (state != FS_FULL);

    // Clear and reset suppress every transfer, including drop accounting.
    assign wr_en   = i_rst_n & ~i_clear & i_valid & o_ready;
    assign rd_en   = i_rst_n & ~i_clear & o_valid & i_ready;
    assign drop_ev = i_rst_n & ~i_clear & i_valid & ~o_ready;

    always_comb begin
        state_nx = state;
        count_nx = count;
        case ({wr_en, rd_en})
            2'b10:   count_nx = count + CW'(1);
            2'b01:   count_nx = count - CW'(1);
            default: count_nx = count;
        endcase
        case (state)
            FS_EMPTY: begin
                if (wr_en) state_nx = FS_PART;
            end
            FS_PART: begin
                if (wr_en && !rd_en && count == LAST) begin
                    state_nx = FS_FULL;
                end else if (rd_en && !wr_en && count == CW'(1)) begin
                    state_nx = FS_EMPTY;
                end
            end
            FS_FULL: begin
                if (rd_en) state_nx = FS_PART;
            end
            default: state_nx = FS_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            state    <= FS_EMPTY;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            if (drop_ev) drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), CNT_W));
            if (wr_en && i_error) err_cnt <= CNT_W'(sat_inc(32'(err_cnt), CNT_W));
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= '{result: i_result, error: i_error, status: in_status};
        end
    end

    assign head       = mem[rd_ptr];
    assign o_result   = o_valid ? head.result : '0;
    assign o_error    = o_valid ? head.error  : 1'b0;
    assign o_status   = o_valid ? head.status : ST_OK;
    assign o_drop_cnt = drop_cnt;
    assign o_err_cnt  = err_cnt;

endmodule

// File: tb/tb_rejestr_wyniku.sv
// Directed self-checking bench for rejestr_wyniku (DEPTH=4, CNT_W=4).
module tb_rejestr_wyniku;
    import wynik_pkg::*;

    localparam int BITS  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_clear;
    logic             i_valid;
    logic             o_ready;
    logic [BITS-1:0]  i_result;
    logic             i_error;
    logic             o_valid;
    logic             i_ready;
    logic [BITS-1:0]  o_result;
    logic             o_error;
    status_t          o_status;
    logic [CNT_W-1:0] o_drop_cnt;
    logic [CNT_W-1:0] o_err_cnt;

    int checks = 0;
    int errors = 0;

    rejestr_wyniku #(
        .BITS  (BITS),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (i_clear),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_result   (i_result),
        .i_error    (i_error),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_error    (o_error),
        .o_status   (o_status),
        .o_drop_cnt (o_drop_cnt),
        .o_err_cnt  (o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [31:0] result, input logic error, input logic ready);
        i_valid  = valid;
        i_result = result;
        i_error  = error;
        i_ready  = ready;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic valid, input logic ready);
        check_output({tag, ".valid"}, 32'(o_valid), 32'(valid));
        check_output({tag, ".ready"}, 32'(o_ready), 32'(ready));
    endtask

    task automatic check_head(input string tag, input logic [31:0] result, input logic error, input status_t status);
        check_output({tag, ".result"}, o_result, result);
        check_output({tag, ".error"}, 32'(o_error), 32'(error));
        check_output({tag, ".status"}, 32'(o_status), 32'(status));
    endtask

    task automatic check_counts(input string tag, input int drop, input int err);
        check_output({tag, ".drop"}, 32'(o_drop_cnt), 32'(drop));
        check_output({tag, ".err"}, 32'(o_err_cnt), 32'(err));
    endtask

    initial begin
        // Reset held two cycles with a write pending
        i_rst_n = 1'b0;
        i_clear = 1'b0;
        apply_stimulus(1'b1, 32'h0000_00AA, 1'b0, 1'b0);
        tick();
        tick();
        check_flags("reset", 1'b0, 1'b1);
        check_head("reset", 32'h0, 1'b0, ST_OK);
        check_counts("reset", 0, 0);
        i_rst_n = 1'b1;

        // Single pass-through
        apply_stimulus(1'b1, 32'h0000_0020, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        check_flags("single", 1'b1, 1'b1);
        check_head("single", 32'h0000_0020, 1'b0, ST_ONEHOT);
        tick();
        check_flags("single_gone", 1'b0, 1'b1);
        check_head("single_gone", 32'h0, 1'b0, ST_OK);

        // Fill to full, hold a dropped write, then drain
        apply_stimulus(1'b1, 32'h0000_0000, 1'b0, 1'b0); tick();
        apply_stimulus(1'b1, 32'h0000_0003, 1'b0, 1'b0); tick();
        apply_stimulus(1'b1, 32'h8000_0000, 1'b0, 1'b0); tick();
        check_flags("fill3", 1'b1, 1'b1);
        apply_stimulus(1'b1, 32'h0000_0000, 1'b1, 1'b0); tick();
        check_flags("full", 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0055, 1'b0, 1'b0);
        tick(); tick(); tick();
        check_counts("drop3", 3, 1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        check_head("drain0", 32'h0000_0000, 1'b0, ST_ZERO);
        tick();
        check_flags("drain1", 1'b1, 1'b1);
        check_head("drain1", 32'h0000_0003, 1'b0, ST_OK);
        tick();
        check_head("drain2", 32'h8000_0000, 1'b0, ST_ONEHOT);
        tick();
        check_head("drain3", 32'h0000_0000, 1'b1, ST_ERR);
        tick();
        check_flags("drained", 1'b0, 1'b1);
        check_counts("drained", 3, 1);

        // Concurrent read and write at count 2 keeps order and occupancy
        apply_stimulus(1'b1, 32'h0000_0011, 1'b0, 1'b0); tick();
        apply_stimulus(1'b1, 32'h0000_0012, 1'b0, 1'b0); tick();
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b1, 32'h0000_0013 + 32'(k), 1'b0, 1'b1);
            check_output("concurrent.head", o_result, 32'h0000_0011 + 32'(k));
            tick();
        end
        apply_stimulus(1'b1, 32'h0000_0018, 1'b0, 1'b0);
        check_flags("concurrent_end", 1'b1, 1'b1);
        check_output("concurrent_end.head", o_result, 32'h0000_0016);
        tick();
        apply_stimulus(1'b1, 32'h0000_0019, 1'b0, 1'b0); tick();
        check_flags("full2", 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'h0000_001A, 1'b0, 1'b1); tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_flags("full_rw", 1'b1, 1'b1);
        check_output("full_rw.head", o_result, 32'h0000_0017);
        check_counts("full_rw", 4, 1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check_output("after_full.head1", o_result, 32'h0000_0018);
        tick();
        check_output("after_full.head2", o_result, 32'h0000_0019);
        tick();
        check_flags("after_full_empty", 1'b0, 1'b1);

        // Clear wins over a simultaneous write and read
        apply_stimulus(1'b1, 32'h0000_0021, 1'b0, 1'b0); tick();
        apply_stimulus(1'b1, 32'h0000_0022, 1'b0, 1'b0); tick();
        apply_stimulus(1'b1, 32'h0000_0023, 1'b1, 1'b0); tick();
        check_counts("pre_clear", 4, 2);
        i_clear = 1'b1;
        apply_stimulus(1'b1, 32'h0000_0024, 1'b0, 1'b1);
        tick();
        i_clear = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_flags("clear", 1'b0, 1'b1);
        check_head("clear", 32'h0, 1'b0, ST_OK);
        check_counts("clear", 0, 0);

        // Drop counter saturation, then a one-cycle reset mid-operation
        apply_stimulus(1'b1, 32'h0000_0001, 1'b0, 1'b0); tick();
        apply_stimulus(1'b1, 32'h0000_0002, 1'b0, 1'b0); tick();
        apply_stimulus(1'b1, 32'h0000_0004, 1'b0, 1'b0); tick();
        apply_stimulus(1'b1, 32'h0000_0008, 1'b1, 1'b0); tick();
        apply_stimulus(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) tick();
        check_flags("saturate", 1'b1, 1'b0);
        check_counts("saturate", 15, 1);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_flags("mid_reset", 1'b0, 1'b1);
        check_head("mid_reset", 32'h0, 1'b0, ST_OK);
        check_counts("mid_reset", 0, 0);
        apply_stimulus(1'b1, 32'h0000_0007, 1'b0, 1'b0); tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_head("post_reset", 32'h0000_0007, 1'b0, ST_OK);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
